ipml_reg_fifo_n: RTL and testbench
==================================

IPML_REG_FIFO_N -- requirements
Module: ipml_reg_fifo_n

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the data width in bits (1..256).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the entry count, a power of two in the range 2..64.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-1, meaning the almost-full threshold (1..DEPTH).
REQ-004 Local AW SHALL equal log2(DEPTH).
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of all entries.
REQ-008 The block SHALL have port data_in_valid, input, 1 bit: upstream offers a word.
REQ-009 The block SHALL have port data_in, input, W bits: upstream word.
REQ-010 The block SHALL have port data_in_ready, output, 1 bit: FIFO can accept a word.
REQ-011 The block SHALL have port data_out_ready, input, 1 bit: downstream accepts a word.
REQ-012 The block SHALL have port data_out, output, W bits: head word.
REQ-013 The block SHALL have port data_out_valid, output, 1 bit: head word valid.
REQ-014 The block SHALL have port level, output, AW+1 bits: number of stored entries.
REQ-015 The block SHALL have port almost_full, output, 1 bit: level >= AFULL_TH.

Function
REQ-016 Write SHALL occur when data_in_valid & data_in_ready; read SHALL occur when data_out_valid & data_out_ready.
REQ-017 data_in_ready SHALL equal (level != DEPTH); data_out_valid SHALL equal (level != 0); both SHALL be combinational from registered state only, never from data_in_valid or data_out_ready.
REQ-018 On a write, data_in SHALL be stored at wptr and wptr SHALL advance by 1 modulo DEPTH.
REQ-019 On a read, rptr SHALL advance by 1 modulo DEPTH.
REQ-020 data_out SHALL equal storage[rptr] combinationally; it SHALL be undefined-free (a stored or reset value) when data_out_valid=0.
REQ-021 Latency SHALL be one cycle: a word written in cycle N SHALL appear on data_out with data_out_valid=1 in cycle N+1 if the FIFO was empty.
REQ-022 Level SHALL be +1 on write-only, -1 on read-only, and unchanged on simultaneous read and write.
REQ-023 When full, a write SHALL NOT be accepted in the same cycle as a read; data_in_ready SHALL rise only in the cycle after level drops.
REQ-024 When empty, read SHALL NOT occur and a same-cycle write SHALL NOT bypass to data_out.
REQ-025 Words SHALL leave in strict arrival order with no loss or duplication across pointer wrap.
REQ-026 flush=1 SHALL set wptr, rptr and level to 0 on the next edge and SHALL override any same-cycle write or read; storage contents SHALL be retained.
REQ-027 almost_full SHALL be registered-state derived and consistent with level in the same cycle.

Reset
REQ-028 While rst_n=0, wptr, rptr and level SHALL be 0, storage SHALL be all-zero, data_out SHALL be 0, data_out_valid SHALL be 0, data_in_ready SHALL be 1, and almost_full SHALL be 0 (AFULL_TH>=1).
REQ-029 Reset assertion mid-transfer SHALL discard all contents immediately; after deassertion the first accepted word SHALL be written at entry 0.

Verification (W=8, DEPTH=4, AFULL_TH=3)
REQ-030 The bench SHALL cover: from reset, write 0x11 with data_out_ready=0 -> next cycle data_out=0x11, data_out_valid=1, level=1.
REQ-031 The bench SHALL cover: write 0xA0..0xA3 back-to-back, sink stalled -> level=4, data_in_ready=0, almost_full=1 from level=3; 0xA4 held upstream and not accepted.
REQ-032 The bench SHALL cover: full FIFO, data_in_valid=1 and data_out_ready=1 for one cycle -> 0xA0 read, no write, level=3; next cycle write accepted.
REQ-033 The bench SHALL cover: continuous valid/ready both sides for 20 words 0x00..0x13 -> output order identical, level constant at 1 after fill, pointers wrap 5 times.
REQ-034 The bench SHALL cover: level=2, flush=1 together with write 0x55 -> next cycle level=0, data_out_valid=0, data_in_ready=1, 0x55 not output.
REQ-035 The bench SHALL cover: rst_n pulsed low at level=3 -> outputs immediately at reset values; after release, write 0x77 then read returns 0x77.

Source files
------------

// File: rtl/ipml_reg_fifo_n.sv
// Register-based FIFO with valid/ready handshake on both sides.
// Head word is read combinationally from storage; flush clears pointers but keeps storage contents.
module ipml_reg_fifo_n #(
  parameter int W        = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             data_in_valid,
  input  logic [W-1:0]     data_in,
  output logic             data_in_ready,
  input  logic             data_out_ready,
  output logic [W-1:0]     data_out,
  output logic             data_out_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_TH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_en, rd_en;

  // Handshake flags depend only on registered level, never on the peer's valid/ready.
  assign data_in_ready  = (level_q != DEPTH_L);
  assign data_out_valid = (level_q != '0);
  assign data_out       = mem_q[rptr_q];
  assign level          = level_q;
  assign almost_full    = (level_q >= AFULL_L);

  assign wr_en = data_in_valid & data_in_ready & ~flush;
  assign rd_en = data_out_valid & data_out_ready & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      if (wr_en && !rd_en)      level_d = level_q + 1'b1;
      else if (rd_en && !wr_en) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      if (wr_en) mem_q[wptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_ipml_reg_fifo_n.sv
// Directed-vector bench for ipml_reg_fifo_n (W=8, DEPTH=4, AFULL_TH=3).
module tb_ipml_reg_fifo_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       data_in_valid;
  logic [7:0] data_in;
  logic       data_in_ready;
  logic       data_out_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic [2:0] level;
  logic       almost_full;

  int vectors = 0;
  int miscompares = 0;

  ipml_reg_fifo_n #(.W(8), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .level          (level),
    .almost_full    (almost_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] dout, input logic vld,
                           input logic rdy, input logic [2:0] lvl, input logic af);
    chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
    chk({tag, ".valid"}, 32'(data_out_valid), 32'(vld));
    chk({tag, ".ready"}, 32'(data_in_ready), 32'(rdy));
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".afull"}, 32'(almost_full), 32'(af));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; data_in_valid = 1'b0; data_in = 8'h00; data_out_ready = 1'b0;
    #2;
    chk_state("reset_async", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    tick(); tick();
    chk_state("reset_held", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();

    // single write, sink stalled; no same-cycle bypass while empty
    data_in_valid = 1'b1; data_in = 8'h11;
    #1;
    chk("nobypass.valid", 32'(data_out_valid), 32'd0);
    tick();
    data_in_valid = 1'b0;
    chk_state("first_word", 8'h11, 1'b1, 1'b1, 3'd1, 1'b0);

    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush1.level", 32'(level), 32'd0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      data_in_valid = 1'b1; data_in = 8'hA0 + 8'(i);
      tick();
      chk("fill.level", 32'(level), 32'(i + 1));
      chk("fill.afull", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
      chk("fill.head", 32'(data_out), 32'hA0);
    end
    data_in = 8'hA4;
    tick(); tick();
    chk_state("full_hold", 8'hA0, 1'b1, 1'b0, 3'd4, 1'b1);

    // full: read and offered write in same cycle -> only read
    data_out_ready = 1'b1;
    tick();
    chk_state("full_rd", 8'hA1, 1'b1, 1'b1, 3'd3, 1'b1);
    data_out_ready = 1'b0;
    tick();
    data_in_valid = 1'b0;
    chk_state("after_full_wr", 8'hA1, 1'b1, 1'b0, 3'd4, 1'b1);

    // drain in order
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.data", 32'(data_out), 32'hA1 + 32'(i));
      tick();
      chk("drain.level", 32'(level), 32'(3 - i));
    end
    chk("drain.valid", 32'(data_out_valid), 32'd0);

    // streaming 20 words with both sides always ready
    data_in_valid = 1'b1; data_in = 8'h00;
    tick();
    for (int k = 1; k < 20; k++) begin
      data_in = 8'(k);
      chk("stream.data", 32'(data_out), 32'(k - 1));
      chk("stream.level", 32'(level), 32'd1);
      tick();
    end
    data_in_valid = 1'b0;
    chk("stream.last", 32'(data_out), 32'h13);
    chk("stream.lvl_last", 32'(level), 32'd1);
    tick();
    chk("stream.empty", 32'(level), 32'd0);
    data_out_ready = 1'b0;

    // flush overrides a same-cycle write
    data_in_valid = 1'b1;
    data_in = 8'h21; tick();
    data_in = 8'h22; tick();
    chk("preflush.level", 32'(level), 32'd2);
    flush = 1'b1; data_in = 8'h55;
    tick();
    flush = 1'b0; data_in_valid = 1'b0;
    chk("flush.level", 32'(level), 32'd0);
    chk("flush.valid", 32'(data_out_valid), 32'd0);
    chk("flush.ready", 32'(data_in_ready), 32'd1);
    chk("flush.afull", 32'(almost_full), 32'd0);
    tick();
    chk("flush.no55", 32'(data_out_valid), 32'd0);

    // asynchronous reset mid-transfer
    data_in_valid = 1'b1;
    data_in = 8'h31; tick();
    data_in = 8'h32; tick();
    data_in = 8'h33; tick();
    data_in_valid = 1'b0;
    chk_state("pre_rst", 8'h31, 1'b1, 1'b1, 3'd3, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("mid_rst", 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    data_in_valid = 1'b1; data_in = 8'h77;
    tick();
    data_in_valid = 1'b0;
    chk_state("post_rst_wr", 8'h77, 1'b1, 1'b1, 3'd1, 1'b0);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    chk("post_rst_rd.level", 32'(level), 32'd0);
    chk("post_rst_rd.valid", 32'(data_out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
